// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// carry preset that turns the adder cell into a two's-complement subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic CARRY_PRESET = 1'b1;

endpackage : sub_pkg

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic cell of the serial subtractor.
module full_adder (
  input  logic X,
  input  logic Y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = X ^ Y ^ ci;
  assign co  = (X & Y) | (X & ci) | (Y & ci);

endmodule : full_adder

// File: rtl/sub_serial_n_bit.sv
// Bit-serial N-bit subtractor: X - Y, LSB first, one full-adder cell with the
// subtrahend inverted and the carry preset to 1. Start/busy/done handshake.
module sub_serial_n_bit
  import sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   xs_q, xs_d;
  logic [N-1:0]   ys_q, ys_d;
  logic [N-1:0]   res_q, res_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           xm_q, xm_d;
  logic           ym_q, ym_d;

  logic           ys_inv;
  logic           fa_sum;
  logic           fa_co;

  assign ys_inv = ~ys_q[0];

  full_adder u_fa (
    .X   (xs_q[0]),
    .Y   (ys_inv),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          xs_d    = X;
          ys_d    = Y;
          res_d   = '0;
          carry_d = CARRY_PRESET;
          cnt_d   = '0;
          xm_d    = X[N-1];
          ym_d    = Y[N-1];
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {fa_sum, res_q[N-1:1]};
        xs_d    = {1'b0, xs_q[N-1:1]};
        ys_d    = {1'b0, ys_q[N-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        // Clearing the counter on exit keeps it within 0..N-1 for any N.
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = res_q;
  assign bout = done & ~carry_q;
  assign ovf  = done & (xm_q ^ ym_q) & (res_q[N-1] ^ xm_q);

endmodule : sub_serial_n_bit

// File: tb/tb_sub_serial_n_bit.sv
// Self-checking bench: arithmetic reference model of X - Y with an N-edge
// latency, compared every cycle, plus directed literal cases.
module tb_sub_serial_n_bit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] X = '0;
  logic [N-1:0] Y = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  sub_serial_n_bit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic int ref_diff(input int x, input int y);
    return (x - y) & ((1 << N) - 1);
  endfunction

  function automatic logic ref_bout(input int x, input int y);
    return (x < y);
  endfunction

  function automatic logic ref_ovf(input int x, input int y);
    int sx, sy, d;
    sx = (x >= (1 << (N - 1))) ? x - (1 << N) : x;
    sy = (y >= (1 << (N - 1))) ? y - (1 << N) : y;
    d  = sx - sy;
    return (d < -(1 << (N - 1))) || (d > (1 << (N - 1)) - 1);
  endfunction

  // Model: an accepted request completes exactly N edges later.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [N-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_ovf  = 1'b0;
  int           remaining = 0;
  int           p_x = 0;
  int           p_y = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_diff <= '0;
      m_bout <= 1'b0; m_ovf <= 1'b0; remaining <= 0;
    end else if (remaining == 0 && start) begin
      m_busy <= 1'b1; m_done <= 1'b0; m_bout <= 1'b0; m_ovf <= 1'b0;
      remaining <= N;
      p_x <= int'(X);
      p_y <= int'(Y);
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
      if (remaining == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_diff <= N'(ref_diff(p_x, p_y));
        m_bout <= ref_bout(p_x, p_y);
        m_ovf  <= ref_ovf(p_x, p_y);
      end
    end
  end

  // Continuous compare; diff is don't-care while running.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("bout", 32'(bout), 32'(m_bout));
      check("ovf",  32'(ovf),  32'(m_ovf));
      if (!m_busy) check("diff", 32'(diff), 32'(m_diff));
    end
  end

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] ed, input logic eb, input logic eo);
    int cycles;
    @(negedge clk);
    start = 1'b1; X = x; Y = y;
    @(negedge clk);
    start = 1'b0; X = N'($urandom); Y = N'($urandom);
    cycles = 1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", 32'(cycles), 32'(N + 1));
    check("op_diff", 32'(diff), 32'(ed));
    check("op_bout", 32'(bout), 32'(eb));
    check("op_ovf",  32'(ovf),  32'(eo));
    $display("[TB] %02h - %02h -> diff=%02h bout=%0b ovf=%0b latency=%0d",
             x, y, diff, bout, ovf, cycles);
  endtask

  initial begin
    int cycles;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    // Issued from DONE: back-to-back restart.
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    // Start pulse with new operands mid-run must be ignored.
    @(negedge clk);
    start = 1'b1; X = 8'h05; Y = 8'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; X = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    cycles = 4;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("ign_latency", 32'(cycles), 32'(N + 1));
    check("ign_diff", 32'(diff), 32'h02);
    $display("[TB] 05 - 03 with ignored restart -> diff=%02h", diff);

    // Asynchronous abort mid-run.
    @(negedge clk);
    start = 1'b1; X = 8'h05; Y = 8'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_idle", 32'(done | busy), 32'd0);
    end
    $display("[TB] mid-run reset -> outputs cleared, idle");

    // Random traffic: starts at any time, operands change every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      X = N'($urandom);
      Y = N'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (N + 2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sub_serial_n_bit
